key_event_fsm: RTL and testbench

Converts the debounced, active-high key level from the debounce stage into single-cycle key events for the control logic. It emits press, release, short-press, long-press and auto-repeat pulses, and maintains a wrapping press counter. It sits directly downstream of debounce (its `key_level` input is debounce's `debounce_out`) and upstream of the mode and counter controllers.

---
 rtl/key_event_fsm.sv | 116 +++++++++++
 tb/tb_key_event_fsm.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/key_event_fsm.sv
// Purpose: turn a debounced key level into press/release/short/long/repeat pulses plus a press counter.
// Latency: press_pulse and key_held one cycle after key_level is first sampled high; release one cycle after first low sample.
// Backpressure: none; every pulse is a one-cycle registered output that downstream logic must take when it appears.
module key_event_fsm #(
  parameter int LONG_CYCLES   = 50,
  parameter int REPEAT_CYCLES = 10,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       key_held,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_THR   = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_THR = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // Resets to 1 so a key already held when reset lifts needs a fresh release/press.
  logic             key_d;

  // Single state machine: edge detect, hold-duration counting and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      key_d         <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      key_held      <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      key_d         <= key_level;
      // Pulses drop back to 0 unless a branch below raises them this cycle.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        IDLE: begin
          if (key_level && !key_d) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            cnt         <= CNT_ONE;
            press_count <= press_count + 8'd1;
            key_held    <= 1'b1;
          end else begin
            key_held    <= 1'b0;
          end
        end

        PRESSED: begin
          // Release is checked first so a release on the threshold edge suppresses long_pulse.
          if (!key_level) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            short_pulse   <= 1'b1;
            cnt           <= '0;
            key_held      <= 1'b0;
          end else if (cnt == LONG_THR) begin
            state      <= REPEAT;
            long_pulse <= 1'b1;
            cnt        <= CNT_ONE;
            key_held   <= 1'b1;
          end else begin
            cnt      <= cnt + CNT_ONE;
            key_held <= 1'b1;
          end
        end

        REPEAT: begin
          // Same release-first priority; a long press never reports short.
          if (!key_level) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            cnt           <= '0;
            key_held      <= 1'b0;
          end else if (cnt == REPEAT_THR) begin
            repeat_pulse <= 1'b1;
            cnt          <= CNT_ONE;
            key_held     <= 1'b1;
          end else begin
            cnt      <= cnt + CNT_ONE;
            key_held <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= '0;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_fsm.sv
// Directed bench for key_event_fsm with LONG_CYCLES=5, REPEAT_CYCLES=3.
// Each tick drives key_level for one cycle and samples outputs 1 ns after the next rising edge.
module tb_key_event_fsm;

  logic       clk;
  logic       rst_n;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       key_held;
  logic [7:0] press_count;

  // Output vector order: {press, release, short, long, repeat, held}
  logic [5:0] pv;
  assign pv = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, key_held};

  int tests = 0;
  int fails = 0;
  int npress;

  key_event_fsm #(
    .LONG_CYCLES  (5),
    .REPEAT_CYCLES(3),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .key_held     (key_held),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive key_level for the current cycle; return sampling the following cycle's outputs.
  task automatic tick(input logic k);
    key_level = k;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic k);
    key_level = k;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    key_level = 1'b0;
    #2;
    do_reset(1'b0);

    // Reset state
    chk("reset_pulses", 32'(pv), 32'h00);
    chk("reset_count", 32'(press_count), 32'd0);
    tick(1'b0);
    tick(1'b0);
    chk("idle_quiet", 32'(pv), 32'h00);

    // Short press: high for 3 cycles then low
    tick(1'b1); chk("short_T1", 32'(pv), 32'b100001);
    chk("short_count", 32'(press_count), 32'd1);
    tick(1'b1); chk("short_T2", 32'(pv), 32'b000001);
    tick(1'b1); chk("short_T3", 32'(pv), 32'b000001);
    tick(1'b0); chk("short_T4", 32'(pv), 32'b011000);
    tick(1'b0); chk("short_T5", 32'(pv), 32'b000000);

    // Long hold with repeat: high for 16 cycles
    for (int i = 1; i <= 16; i++) begin
      logic [5:0] e;
      tick(1'b1);
      e = 6'b000001;
      if (i == 1) e[5] = 1'b1;
      if (i == 6) e[2] = 1'b1;
      if (i == 9 || i == 12 || i == 15) e[1] = 1'b1;
      chk($sformatf("long_T%0d", i), 32'(pv), 32'(e));
    end
    tick(1'b0); chk("long_T17", 32'(pv), 32'b010000);
    chk("long_count", 32'(press_count), 32'd2);
    tick(1'b0); chk("long_T18", 32'(pv), 32'b000000);

    // Release exactly on the long threshold edge
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1);
      chk($sformatf("thr_T%0d", i), 32'(pv), (i == 1) ? 32'b100001 : 32'b000001);
    end
    tick(1'b0); chk("thr_T6", 32'(pv), 32'b011000);
    tick(1'b0); chk("thr_T7", 32'(pv), 32'b000000);
    tick(1'b0); chk("thr_T8", 32'(pv), 32'b000000);
    chk("thr_count", 32'(press_count), 32'd3);

    // Held through reset: no press until a fresh 0->1
    do_reset(1'b1);
    chk("hold_rst_count", 32'(press_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      chk($sformatf("hold_rst_nopress%0d", i), 32'(pv), 32'b000000);
    end
    tick(1'b0); chk("hold_rst_low", 32'(pv), 32'b000000);
    tick(1'b1); chk("hold_rst_press", 32'(pv), 32'b100001);
    chk("hold_rst_count1", 32'(press_count), 32'd1);
    tick(1'b0); chk("hold_rst_rel", 32'(pv), 32'b011000);
    tick(1'b0);

    // Counter wrap: 255 presses -> 255, 256th -> 0
    do_reset(1'b0);
    tick(1'b0);
    npress = 0;
    for (int n = 0; n < 255; n++) begin
      tick(1'b1); if (press_pulse) npress++;
      tick(1'b0); if (press_pulse) npress++;
    end
    chk("wrap_255", 32'(press_count), 32'd255);
    tick(1'b1); if (press_pulse) npress++;
    chk("wrap_0", 32'(press_count), 32'd0);
    tick(1'b0); if (press_pulse) npress++;
    chk("wrap_rel", 32'(pv), 32'b011000);
    chk("wrap_npress", 32'(npress), 32'd256);
    tick(1'b0);

    // Mid-hold reset while in REPEAT
    for (int i = 1; i <= 8; i++) tick(1'b1);
    chk("mid_before_held", 32'(key_held), 32'd1);
    chk("mid_before_count", 32'(press_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_pulses", 32'(pv), 32'b000000);
    chk("mid_async_count", 32'(press_count), 32'd0);
    @(posedge clk); #1;
    key_level = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      chk($sformatf("mid_norel%0d", i), 32'(pv), 32'b000000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
